// File: rtl/fp_pkg.sv
// IEEE-754 single-precision field widths, class codes and a classifier helper.
// Latency: combinational only (function, no state).
// Backpressure: n/a, nothing in here has flow control.
package fp_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    typedef enum logic [1:0] {
        CLS_NORM = 2'b00,   // normal or denormal
        CLS_ZERO = 2'b01,   // +0 or -0
        CLS_INF  = 2'b10,   // +inf or -inf
        CLS_NAN  = 2'b11    // quiet or signalling NaN
    } fp_class_e;

    // Sign is ignored: -0 and +0 both map to CLS_ZERO, and likewise for inf.
    function automatic fp_class_e fp_class(input logic [FP_W-1:0] x);
        logic [EXP_W-1:0] exp_f;
        logic [MAN_W-1:0] man_f;
        exp_f = x[FP_W-2 -: EXP_W];
        man_f = x[MAN_W-1:0];
        if (exp_f == '1) begin
            fp_class = (man_f != '0) ? CLS_NAN : CLS_INF;
        end else if (exp_f == '0 && man_f == '0) begin
            fp_class = CLS_ZERO;
        end else begin
            fp_class = CLS_NORM;
        end
    endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and sync clear.
// Latency: an entry written at edge N is on head_dat_o right after edge N.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
//
// Ports: clk_i/rst_n_i (async active-low), clr_i (sync flush), push_i/push_dat_i,
//        pop_i, head_dat_o (zero when empty), count_o, full_o, empty_o.
module fp_sync_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_dat_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

    // A pop frees the head slot in the same cycle, so a push is legal when full
    // as long as it is paired with a pop.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Head is forced to zero when empty so the stale slot never leaks out.
    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked purely by the pointers/count.
    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/fpmul_result_capture.sv
// Captures FPmul results (tracked by a VIN delay line) with a class tag into a FIFO.
// Latency: result pushed at edge N shows on RD_VALID/RD_DATA right after edge N.
// Backpressure: none upstream; a result arriving while FULL without a pop is dropped, OVF sticks.
//
// Ports: CLK, RST_n (async active-low), VIN (operands into FPmul), DOUT (FP_Z),
//        CLR (sync flush incl. in-flight), RD_READY/RD_VALID/RD_DATA/RD_CLASS (FWFT read),
//        COUNT, FULL, OVF (sticky drop flag).
module fpmul_result_capture
    import fp_pkg::*;
#(
    parameter int W       = 32,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 16,
    parameter int CW      = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          VIN,
    input  logic [W-1:0]  DOUT,
    input  logic          CLR,
    input  logic          RD_READY,
    output logic          RD_VALID,
    output logic [W-1:0]  RD_DATA,
    output logic [1:0]    RD_CLASS,
    output logic [CW-1:0] COUNT,
    output logic          FULL,
    output logic          OVF
);

    logic [LATENCY-1:0] vd_q, vd_d;
    logic               ovf_q, ovf_d;
    logic               push;
    logic               pop;
    logic               empty;
    fp_class_e          push_cls;
    logic [W+1:0]       head_dat;

    // Delay line mirrors the multiplier pipeline: its last stage marks the cycle
    // in which DOUT carries the result of an earlier VIN. CLR also clears it so
    // that results already inside FPmul are never captured.
    always_comb begin
        vd_d = vd_q;
        if (CLR) begin
            vd_d = '0;
        end else begin
            vd_d[0] = VIN;
            for (int i = 1; i < LATENCY; i++) begin
                vd_d[i] = vd_q[i-1];
            end
        end
    end

    assign push     = vd_q[LATENCY-1];
    assign pop      = RD_VALID && RD_READY;
    assign push_cls = fp_class(DOUT);

    // Drop happens only when full and the head is not leaving this cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (CLR) begin
            ovf_d = 1'b0;
        end else if (push && FULL && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            vd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            vd_q  <= vd_d;
            ovf_q <= ovf_d;
        end
    end

    fp_sync_fifo #(
        .W     (W + 2),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_n_i    (RST_n),
        .clr_i      (CLR),
        .push_i     (push && !CLR),
        .push_dat_i ({push_cls, DOUT}),
        .pop_i      (pop && !CLR),
        .head_dat_o (head_dat),
        .count_o    (COUNT),
        .full_o     (FULL),
        .empty_o    (empty)
    );

    assign RD_VALID = !empty;
    assign RD_DATA  = head_dat[W-1:0];
    assign RD_CLASS = head_dat[W+1:W];
    assign OVF      = ovf_q;

endmodule
